fan_in_fifo: RTL and testbench

Two-to-one message merger at the receiving end of a link: the mirror of the fan-out element. It accepts framed token messages on two forward inputs, arbitrates between them round-robin at message granularity, and funnels the winner through a FIFO onto a single forward output. Back-pressure (nack) is returned per input.

---
 rtl/fan_in_fifo_if.sv | 39 +++
 rtl/fan_in_fifo.sv | 120 ++++++++++++
 tb/tb_fan_in_fifo.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fan_in_fifo_if.sv
// Token types and the grouped link interface for the two-to-one message merger.
// The package lives here so the interface file is self-contained in any compile order.
package fan_in_fifo_pkg;
  localparam int WIDTH_DATA = 32;

  typedef struct packed {
    logic                  v;
    logic                  a;
    logic                  r;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
  } BTk_t;
endpackage

interface fan_in_fifo_if;
  import fan_in_fifo_pkg::*;

  FTk_t       I_FTk0;
  BTk_t       O_BTk0;
  FTk_t       I_FTk1;
  BTk_t       O_BTk1;
  FTk_t       O_FTk;
  BTk_t       I_BTk;
  logic [1:0] O_Grt;
  logic       O_Err;

  modport master (
    output I_FTk0, I_FTk1, I_BTk,
    input  O_BTk0, O_BTk1, O_FTk, O_Grt, O_Err
  );

  modport slave (
    input  I_FTk0, I_FTk1, I_BTk,
    output O_BTk0, O_BTk1, O_FTk, O_Grt, O_Err
  );
endinterface

// File: rtl/fan_in_fifo.sv
// Two-to-one message merger: round-robin arbitration per message, output FIFO,
// per-port nack and sticky framing-error detection from the head length field.
module fan_in_fifo #(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_LENGTH = 8,
  parameter int DEPTH_FIFO   = 16
) (
  input logic          clock,
  input logic          reset,
  fan_in_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH_FIFO);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH_FIFO);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  r_state;
  logic [1:0]              r_grt;
  logic                    r_ptr;
  logic                    r_inMsg;
  logic                    r_err;
  logic [WIDTH_LENGTH-1:0] r_cnt;
  logic [WIDTH_DATA+1:0]   r_mem [DEPTH_FIFO];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;

  logic                    w_full, w_notEmpty, w_nack0, w_nack1;
  logic                    w_tokV, w_tokA, w_tokR;
  logic [WIDTH_DATA-1:0]   w_tokD;
  logic                    w_acc, w_pop, w_req0, w_req1, w_fErr;
  logic [WIDTH_LENGTH-1:0] w_cntDec, w_newCnt;
  logic [WIDTH_DATA+1:0]   w_head;

  assign w_full     = (r_count == FULL);
  assign w_notEmpty = (r_count != '0);

  // Nacks depend only on registered state so no input-to-nack path exists.
  assign w_nack0 = !(r_state == BUSY && r_grt[0] && !w_full);
  assign w_nack1 = !(r_state == BUSY && r_grt[1] && !w_full);

  assign w_tokV = r_grt[1] ? bus.I_FTk1.v : bus.I_FTk0.v;
  assign w_tokA = r_grt[1] ? bus.I_FTk1.a : bus.I_FTk0.a;
  assign w_tokR = r_grt[1] ? bus.I_FTk1.r : bus.I_FTk0.r;
  assign w_tokD = r_grt[1] ? bus.I_FTk1.d : bus.I_FTk0.d;

  assign w_acc  = (r_state == BUSY) && w_tokV && !w_full;
  assign w_pop  = w_notEmpty && !bus.I_BTk.n;
  assign w_req0 = bus.I_FTk0.v && bus.I_FTk0.a;
  assign w_req1 = bus.I_FTk1.v && bus.I_FTk1.a;

  // A head met mid-message is flagged but still reloads the length counter.
  assign w_cntDec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
  assign w_newCnt = w_tokA ? w_tokD[WIDTH_LENGTH-1:0] : w_cntDec;
  assign w_fErr   = (w_tokR && w_newCnt != '0) ||
                    (!w_tokA && r_cnt == '0) ||
                    (w_tokA && r_inMsg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grt   <= 2'b00;
      r_ptr   <= 1'b0;
      r_inMsg <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            r_state <= BUSY;
            r_grt   <= (w_req0 && (!w_req1 || !r_ptr)) ? 2'b01 : 2'b10;
          end
        end
        BUSY: begin
          if (w_acc) begin
            r_cnt   <= w_newCnt;
            r_inMsg <= 1'b1;
            if (w_fErr) r_err <= 1'b1;
            if (w_tokR) begin
              r_state <= IDLE;
              r_grt   <= 2'b00;
              r_ptr   <= r_grt[0];
              r_inMsg <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_acc) r_mem[r_wptr] <= {w_tokA, w_tokR, w_tokD};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_acc && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_acc && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_head     = r_mem[r_rptr];
  assign bus.O_FTk  = '{v: w_notEmpty,
                        a: w_notEmpty & w_head[WIDTH_DATA+1],
                        r: w_notEmpty & w_head[WIDTH_DATA],
                        d: w_notEmpty ? w_head[WIDTH_DATA-1:0] : '0};
  assign bus.O_BTk0 = '{n: w_nack0};
  assign bus.O_BTk1 = '{n: w_nack1};
  assign bus.O_Grt  = r_grt;
  assign bus.O_Err  = r_err;
endmodule

// File: tb/tb_fan_in_fifo.sv
// Directed self-checking bench for fan_in_fifo: one task per scenario, tokens
// scoreboarded from what each source handed over against what the sink received.
module tb_fan_in_fifo;
  import fan_in_fifo_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   assertions = 0;
  int   failures = 0;
  FTk_t expQ[$];
  FTk_t gotQ[$];
  int   gotCyc[$];

  fan_in_fifo_if bus ();

  fan_in_fifo #(.WIDTH_DATA(32), .WIDTH_LENGTH(8), .DEPTH_FIFO(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Record every token the sink takes; a pop happens at the following posedge.
  always @(negedge clock) begin
    if (!reset && bus.O_FTk.v && !bus.I_BTk.n) begin
      gotQ.push_back(bus.O_FTk);
      gotCyc.push_back(cyc);
    end
  end

  function automatic logic nackOf(input int port);
    return (port == 1) ? bus.O_BTk1.n : bus.O_BTk0.n;
  endfunction

  task automatic drivePort(input int port, input FTk_t tok);
    if (port == 1) bus.I_FTk1 = tok;
    else           bus.I_FTk0 = tok;
  endtask

  // Send one message (head + nBodies), holding each token until it is accepted.
  task automatic applyStimulus(input int port, input int nBodies, input logic [7:0] lenField,
                               input logic [15:0] tag, input int stopAfter,
                               output int firstAcc, output int lastAcc, output logic [1:0] grtAtHead);
    FTk_t tok;
    int   n;
    bit   accepted;
    n = nBodies + 1;
    firstAcc = -1;
    lastAcc = -1;
    grtAtHead = 2'b00;
    for (int i = 0; i < n; i++) begin
      if (stopAfter >= 0 && i >= stopAfter) break;
      tok.v = 1'b1;
      tok.a = (i == 0);
      tok.r = (i == n - 1);
      tok.d = (i == 0) ? {tag, 8'h00, lenField} : {tag, 8'(i), 8'hB0};
      drivePort(port, tok);
      accepted = 1'b0;
      for (int b = 0; b < 200 && !accepted; b++) begin
        @(negedge clock);
        if (nackOf(port) == 1'b0) begin
          accepted = 1'b1;
          if (i == 0) begin
            firstAcc = cyc;
            grtAtHead = bus.O_Grt;
          end
          lastAcc = cyc;
          expQ.push_back(tok);
        end
        @(posedge clock);
        #1;
      end
      if (!accepted) begin
        assertions++;
        failures++;
        $display("[TB] FAIL accept_timeout port=%0d token=%0d got=nacked expected=accepted", port, i);
        break;
      end
    end
    drivePort(port, '0);
  endtask

  task automatic waitDrain(input int need);
    for (int b = 0; b < 300; b++) begin
      @(negedge clock);
      if (gotQ.size() >= need && !bus.O_FTk.v) break;
    end
  endtask

  task automatic clearQueues;
    expQ.delete();
    gotQ.delete();
    gotCyc.delete();
  endtask

  task automatic applyReset;
    reset = 1'b1;
    bus.I_FTk0 = '0;
    bus.I_FTk1 = '0;
    bus.I_BTk = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clearQueues();
  endtask

  task automatic test_reset;
    applyReset();
    @(negedge clock);
    assertions++; if (bus.O_Grt !== 2'b00) begin failures++; $display("[TB] FAIL reset_grt got=%b expected=00", bus.O_Grt); end
    assertions++; if (bus.O_Err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b expected=0", bus.O_Err); end
    assertions++; if (bus.O_FTk !== '0) begin failures++; $display("[TB] FAIL reset_ftk got=%h expected=0", bus.O_FTk); end
    assertions++; if (bus.O_BTk0.n !== 1'b1) begin failures++; $display("[TB] FAIL reset_nack0 got=%b expected=1", bus.O_BTk0.n); end
    assertions++; if (bus.O_BTk1.n !== 1'b1) begin failures++; $display("[TB] FAIL reset_nack1 got=%b expected=1", bus.O_BTk1.n); end
  endtask

  task automatic test_single_message;
    int t0, f, l;
    logic [1:0] g;
    clearQueues();
    @(posedge clock); #1;
    t0 = cyc;
    applyStimulus(0, 3, 8'd3, 16'h0A00, -1, f, l, g);
    assertions++; if (f !== t0 + 1) begin failures++; $display("[TB] FAIL single_head_cycle got=%0d expected=%0d", f, t0 + 1); end
    assertions++; if (g !== 2'b01) begin failures++; $display("[TB] FAIL single_grant got=%b expected=01", g); end
    waitDrain(4);
    assertions++; if (gotQ.size() !== 4) begin failures++; $display("[TB] FAIL single_count got=%0d expected=4", gotQ.size()); end
    for (int i = 0; i < 4 && i < gotQ.size(); i++) begin
      assertions++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL single_token%0d got=%h expected=%h", i, gotQ[i], expQ[i]); end
      assertions++; if (gotCyc[i] !== t0 + 2 + i) begin failures++; $display("[TB] FAIL single_out_cycle%0d got=%0d expected=%0d", i, gotCyc[i], t0 + 2 + i); end
    end
    assertions++; if (bus.O_Grt !== 2'b00) begin failures++; $display("[TB] FAIL single_release got=%b expected=00", bus.O_Grt); end
    assertions++; if (bus.O_Err !== 1'b0) begin failures++; $display("[TB] FAIL single_err got=%b expected=0", bus.O_Err); end
  endtask

  task automatic test_contention;
    int t0, f0, l0, f1, l1, fx, lx;
    logic [1:0] g0, g1, gx;
    applyReset();
    @(posedge clock); #1;
    t0 = cyc;
    fork
      applyStimulus(0, 1, 8'd1, 16'h0C00, -1, f0, l0, g0);
      applyStimulus(1, 1, 8'd1, 16'h0C01, -1, f1, l1, g1);
    join
    assertions++; if (f0 !== t0 + 1) begin failures++; $display("[TB] FAIL cont1_port0_first got=%0d expected=%0d", f0, t0 + 1); end
    assertions++; if (f1 !== l0 + 2) begin failures++; $display("[TB] FAIL cont1_port1_after got=%0d expected=%0d", f1, l0 + 2); end
    // Port 0 alone moves the round-robin pointer to port 1 for the next clash.
    applyStimulus(0, 0, 8'd0, 16'h0C02, -1, fx, lx, gx);
    @(posedge clock); #1;
    t0 = cyc;
    fork
      applyStimulus(0, 1, 8'd1, 16'h0C03, -1, f0, l0, g0);
      applyStimulus(1, 1, 8'd1, 16'h0C04, -1, f1, l1, g1);
    join
    assertions++; if (f1 !== t0 + 1) begin failures++; $display("[TB] FAIL cont2_port1_first got=%0d expected=%0d", f1, t0 + 1); end
    assertions++; if (f0 !== l1 + 2) begin failures++; $display("[TB] FAIL cont2_port0_after got=%0d expected=%0d", f0, l1 + 2); end
    assertions++; if (g1 !== 2'b10) begin failures++; $display("[TB] FAIL cont2_grant got=%b expected=10", g1); end
    waitDrain(9);
    assertions++; if (gotQ.size() !== 9) begin failures++; $display("[TB] FAIL cont_count got=%0d expected=9", gotQ.size()); end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      assertions++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL cont_token%0d got=%h expected=%h", i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_back_pressure;
    int f, l;
    logic [1:0] g;
    clearQueues();
    bus.I_BTk.n = 1'b1;
    fork
      applyStimulus(0, 20, 8'd20, 16'h0B00, -1, f, l, g);
      begin
        repeat (25) @(posedge clock);
        @(negedge clock);
        assertions++; if (expQ.size() !== 16) begin failures++; $display("[TB] FAIL bp_accepted got=%0d expected=16", expQ.size()); end
        assertions++; if (bus.O_BTk0.n !== 1'b1) begin failures++; $display("[TB] FAIL bp_nack_full got=%b expected=1", bus.O_BTk0.n); end
        assertions++; if (gotQ.size() !== 0) begin failures++; $display("[TB] FAIL bp_held got=%0d expected=0", gotQ.size()); end
        @(posedge clock); #1;
        bus.I_BTk.n = 1'b0;
      end
    join
    waitDrain(21);
    assertions++; if (gotQ.size() !== 21) begin failures++; $display("[TB] FAIL bp_count got=%0d expected=21", gotQ.size()); end
    for (int i = 0; i < 21 && i < gotQ.size() && i < expQ.size(); i++) begin
      assertions++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL bp_token%0d got=%h expected=%h", i, gotQ[i], expQ[i]); end
    end
    assertions++; if (bus.O_Err !== 1'b0) begin failures++; $display("[TB] FAIL bp_err got=%b expected=0", bus.O_Err); end
  endtask

  task automatic test_unit_message;
    int f, l;
    logic [1:0] g;
    FTk_t want;
    clearQueues();
    applyStimulus(1, 0, 8'd0, 16'h0E00, -1, f, l, g);
    @(negedge clock);
    assertions++; if (bus.O_Grt !== 2'b00) begin failures++; $display("[TB] FAIL unit_release got=%b expected=00", bus.O_Grt); end
    assertions++; if (g !== 2'b10) begin failures++; $display("[TB] FAIL unit_grant got=%b expected=10", g); end
    waitDrain(1);
    want = '{v: 1'b1, a: 1'b1, r: 1'b1, d: 32'h0E00_0000};
    assertions++; if (gotQ.size() !== 1) begin failures++; $display("[TB] FAIL unit_count got=%0d expected=1", gotQ.size()); end
    else begin
      assertions++; if (gotQ[0] !== want) begin failures++; $display("[TB] FAIL unit_token got=%h expected=%h", gotQ[0], want); end
    end
    assertions++; if (bus.O_Err !== 1'b0) begin failures++; $display("[TB] FAIL unit_err got=%b expected=0", bus.O_Err); end
  endtask

  task automatic test_framing_error;
    int f, l;
    logic [1:0] g;
    clearQueues();
    applyStimulus(0, 1, 8'd2, 16'h0F00, -1, f, l, g);
    @(negedge clock);
    assertions++; if (bus.O_Err !== 1'b1) begin failures++; $display("[TB] FAIL ferr_set got=%b expected=1", bus.O_Err); end
    assertions++; if (bus.O_Grt !== 2'b00) begin failures++; $display("[TB] FAIL ferr_release got=%b expected=00", bus.O_Grt); end
    applyStimulus(1, 1, 8'd1, 16'h0F01, -1, f, l, g);
    waitDrain(4);
    assertions++; if (gotQ.size() !== 4) begin failures++; $display("[TB] FAIL ferr_count got=%0d expected=4", gotQ.size()); end
    for (int i = 0; i < 4 && i < gotQ.size() && i < expQ.size(); i++) begin
      assertions++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL ferr_token%0d got=%h expected=%h", i, gotQ[i], expQ[i]); end
    end
    assertions++; if (bus.O_Err !== 1'b1) begin failures++; $display("[TB] FAIL ferr_sticky got=%b expected=1", bus.O_Err); end
  endtask

  task automatic test_reset_mid_message;
    int f, l;
    logic [1:0] g;
    clearQueues();
    bus.I_BTk.n = 1'b1;
    applyStimulus(0, 4, 8'd4, 16'h0D00, 2, f, l, g);
    reset = 1'b1;
    @(negedge clock);
    assertions++; if (bus.O_FTk.v !== 1'b0) begin failures++; $display("[TB] FAIL rmid_valid got=%b expected=0", bus.O_FTk.v); end
    assertions++; if (bus.O_Grt !== 2'b00) begin failures++; $display("[TB] FAIL rmid_grt got=%b expected=00", bus.O_Grt); end
    assertions++; if (bus.O_BTk0.n !== 1'b1 || bus.O_BTk1.n !== 1'b1) begin failures++; $display("[TB] FAIL rmid_nacks got=%b%b expected=11", bus.O_BTk0.n, bus.O_BTk1.n); end
    assertions++; if (bus.O_Err !== 1'b0) begin failures++; $display("[TB] FAIL rmid_err got=%b expected=0", bus.O_Err); end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.I_BTk.n = 1'b0;
    clearQueues();
    applyStimulus(1, 2, 8'd2, 16'h0D01, -1, f, l, g);
    waitDrain(3);
    assertions++; if (gotQ.size() !== 3) begin failures++; $display("[TB] FAIL rmid_fresh_count got=%0d expected=3", gotQ.size()); end
    for (int i = 0; i < 3 && i < gotQ.size() && i < expQ.size(); i++) begin
      assertions++; if (gotQ[i] !== expQ[i]) begin failures++; $display("[TB] FAIL rmid_token%0d got=%h expected=%h", i, gotQ[i], expQ[i]); end
    end
    assertions++; if (bus.O_Err !== 1'b0) begin failures++; $display("[TB] FAIL rmid_fresh_err got=%b expected=0", bus.O_Err); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.I_FTk0 = '0;
    bus.I_FTk1 = '0;
    bus.I_BTk = '0;
    test_reset();
    test_single_message();
    test_contention();
    test_back_pressure();
    test_unit_message();
    test_framing_error();
    test_reset_mid_message();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
